// File: rtl/config_bus_master_pkg.sv
// Shared config BRAM word map, bit indices and FSM state encodings.
// Both the CPU-side master and the FPGA-side config logic import this.
package config_bus_master_pkg;

    localparam int BRAM_SEL_W  = 4;
    localparam int BRAM_ADDR_W = 8;
    localparam int WORD_W      = 16;

    localparam logic [BRAM_SEL_W-1:0] BRAM_CONFIG_SELECT = 4'd1;

    localparam logic [5:0] CTRL_FLAG         = 6'h00;
    localparam logic [5:0] FPGA_INFO         = 6'h01;
    localparam logic [5:0] SEQ_CYCLE         = 6'h02;
    localparam logic [5:0] SEQ_DIV           = 6'h03;
    localparam logic [5:0] WAVELENGTH        = 6'h08;
    localparam logic [5:0] SEQ_SYNC_TIME_0   = 6'h09;
    localparam logic [5:0] SEQ_SYNC_TIME_1   = 6'h0A;
    localparam logic [5:0] SEQ_SYNC_TIME_2   = 6'h0B;
    localparam logic [5:0] SEQ_SYNC_TIME_3   = 6'h0C;
    localparam logic [5:0] MOD_CYCLE         = 6'h0D;
    localparam logic [5:0] MOD_DIV           = 6'h0E;
    localparam logic [5:0] MOD_SYNC_TIME_0   = 6'h0F;
    localparam logic [5:0] MOD_SYNC_TIME_1   = 6'h10;
    localparam logic [5:0] MOD_SYNC_TIME_2   = 6'h11;
    localparam logic [5:0] MOD_SYNC_TIME_3   = 6'h12;
    localparam logic [5:0] CLK_INIT_FLAG     = 6'h13;

    localparam int CTRL_MOD_EN_BIT = 0;
    localparam int CTRL_SEQ_EN_BIT = 1;
    localparam int INIT_MOD_BIT    = 0;
    localparam int INIT_SEQ_BIT    = 1;

    typedef logic [3:0] state_t;
    localparam state_t S_IDLE      = 4'd0;
    localparam state_t S_WRITE     = 4'd1;
    localparam state_t S_SET_INIT  = 4'd2;
    localparam state_t S_POLL_WAIT = 4'd3;
    localparam state_t S_POLL_RD   = 4'd4;
    localparam state_t S_POLL_SMP  = 4'd5;
    localparam state_t S_RD_ISSUE  = 4'd6;
    localparam state_t S_RD_WAIT   = 4'd7;
    localparam state_t S_RESPOND   = 4'd8;

endpackage

// File: rtl/cpu_bus_if.sv
// CPU-side BRAM access bus shared by all BRAM initiators/targets.
interface cpu_bus_if;
    import config_bus_master_pkg::*;

    logic                   BUS_CLK;
    logic                   EN;
    logic                   WE;
    logic [BRAM_SEL_W-1:0]  BRAM_SELECT;
    logic [BRAM_ADDR_W-1:0] BRAM_ADDR;
    logic [WORD_W-1:0]      DATA_IN;

    modport master_port (output BUS_CLK, EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN);
    modport slave_port  (input  BUS_CLK, EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN);
endinterface

// File: rtl/config_bus_master.sv
// Command-to-CPU-bus initiator for the config BRAM: burst word writes/reads,
// plus the clock-init flag handshake (set, then poll until cleared).
module config_bus_master
    import config_bus_master_pkg::*;
#(
    parameter int RD_LATENCY    = 2,
    parameter int POLL_INTERVAL = 8,
    parameter int POLL_TIMEOUT  = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [5:0]  CMD_ADDR,
    input  logic [1:0]  CMD_LEN,
    input  logic [63:0] CMD_DATA,
    input  logic [1:0]  CMD_INIT,
    output logic        RSP_VALID,
    output logic [63:0] RSP_DATA,
    output logic        RSP_ERR,
    cpu_bus_if.master_port CPU_BUS,
    input  logic [15:0] CPU_DATA_IN
);

    localparam int TW = $clog2(POLL_INTERVAL + RD_LATENCY + 1);
    localparam int PW = $clog2(POLL_TIMEOUT + 1);

    state_t         state;
    logic           ready_en;
    logic [5:0]     addr_q;
    logic [1:0]     len_q;
    logic [63:0]    data_q;
    logic [1:0]     init_q;
    logic [1:0]     idx;
    logic [TW-1:0]  tmr;
    logic [PW-1:0]  polls;
    logic [PW-1:0]  polls_nxt;
    logic [5:0]     word_addr;

    assign polls_nxt = polls + 1'b1;
    assign word_addr = addr_q + {4'b0000, idx};

    // ready_en keeps READY low during reset and through the release cycle
    assign CMD_READY = (state == S_IDLE) && ready_en;
    assign RSP_VALID = (state == S_RESPOND);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            ready_en <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            data_q   <= '0;
            init_q   <= '0;
            idx      <= '0;
            tmr      <= '0;
            polls    <= '0;
            RSP_DATA <= '0;
            RSP_ERR  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                S_IDLE: if (CMD_VALID && CMD_READY) begin
                    addr_q   <= CMD_ADDR;
                    len_q    <= CMD_LEN;
                    data_q   <= CMD_DATA;
                    init_q   <= CMD_WRITE ? CMD_INIT : 2'b00;
                    idx      <= '0;
                    RSP_DATA <= '0;
                    RSP_ERR  <= 1'b0;
                    state    <= CMD_WRITE ? S_WRITE : S_RD_ISSUE;
                end
                S_WRITE: begin
                    if (idx == len_q)
                        state <= (init_q != 2'b00) ? S_SET_INIT : S_RESPOND;
                    else
                        idx <= idx + 1'b1;
                end
                S_SET_INIT: begin
                    polls <= '0;
                    tmr   <= '0;
                    state <= S_POLL_WAIT;
                end
                S_POLL_WAIT: begin
                    if (tmr == TW'(POLL_INTERVAL - 1)) begin
                        tmr   <= '0;
                        state <= S_POLL_RD;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_POLL_RD: begin
                    tmr   <= TW'(1);
                    state <= S_POLL_SMP;
                end
                S_POLL_SMP: begin
                    if (tmr == TW'(RD_LATENCY)) begin
                        polls <= polls_nxt;
                        tmr   <= '0;
                        if ((CPU_DATA_IN[1:0] & init_q) == 2'b00) begin
                            state <= S_RESPOND;
                        end else if (polls_nxt == PW'(POLL_TIMEOUT)) begin
                            RSP_ERR <= 1'b1;
                            state   <= S_RESPOND;
                        end else begin
                            state <= S_POLL_WAIT;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_RD_ISSUE: begin
                    tmr   <= TW'(1);
                    state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (tmr == TW'(RD_LATENCY)) begin
                        RSP_DATA[{idx, 4'b0000} +: 16] <= CPU_DATA_IN;
                        if (idx == len_q) begin
                            state <= S_RESPOND;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_RD_ISSUE;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_RESPOND: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Bus is decoded straight from state so reset releases it asynchronously
    assign CPU_BUS.BUS_CLK     = CLK;
    assign CPU_BUS.BRAM_SELECT = BRAM_CONFIG_SELECT;

    always_comb begin
        CPU_BUS.EN        = 1'b0;
        CPU_BUS.WE        = 1'b0;
        CPU_BUS.BRAM_ADDR = '0;
        CPU_BUS.DATA_IN   = '0;
        case (state)
            S_WRITE: begin
                CPU_BUS.EN        = 1'b1;
                CPU_BUS.WE        = 1'b1;
                CPU_BUS.BRAM_ADDR = {2'b00, word_addr};
                CPU_BUS.DATA_IN   = data_q[{idx, 4'b0000} +: 16];
            end
            S_SET_INIT: begin
                CPU_BUS.EN        = 1'b1;
                CPU_BUS.WE        = 1'b1;
                CPU_BUS.BRAM_ADDR = {2'b00, CLK_INIT_FLAG};
                CPU_BUS.DATA_IN   = {14'd0, init_q};
            end
            S_POLL_RD: begin
                CPU_BUS.EN        = 1'b1;
                CPU_BUS.BRAM_ADDR = {2'b00, CLK_INIT_FLAG};
            end
            S_RD_ISSUE: begin
                CPU_BUS.EN        = 1'b1;
                CPU_BUS.BRAM_ADDR = {2'b00, word_addr};
            end
            default: ;
        endcase
    end

endmodule

// File: doc/config_bus_master.md
Name: config_bus_master

Overview:
- CPU-side initiator for the config BRAM (port A, select `BRAM_CONFIG_SELECT).
- Turns single-command requests into CPU bus word writes and reads: control flags, mod/seq cycle and div, wavelength, 64-bit sync times.
- Writes the clock-init flag word (0x13) and polls it until the FPGA-side config logic clears it.
- Reads FPGA info (0x01) back; sits between the host/command logic and cpu_bus_if.

Parameters:
- RD_LATENCY, 2, cycles from the EN+address cycle to valid CPU_DATA_IN.
- POLL_INTERVAL, 8, cycles between init-flag poll reads.
- POLL_TIMEOUT, 64, maximum poll reads before error.

Ports:
- CLK  in  1  single system clock; CPU_BUS.BUS_CLK is driven from CLK.
- RST_N  in  1  reset, asynchronous, active-low.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted when VALID&READY.
- CMD_WRITE  in  1  1=write, 0=read.
- CMD_ADDR  in  6  first word address.
- CMD_LEN  in  2  word count minus 1 (1..4 words).
- CMD_DATA  in  64  write data; word i = CMD_DATA[16i+15:16i].
- CMD_INIT  in  2  init bits to set after writes (bit0 mod, bit1 seq); ignored on reads.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_DATA  out  64  read data, same word packing; unused words zero.
- RSP_ERR  out  1  poll timeout, qualified by RSP_VALID.
- CPU_BUS  cpu_bus_if.master_port  -  drives EN, WE, BRAM_SELECT, BRAM_ADDR[5:0] (upper bits 0), DATA_IN.
- CPU_DATA_IN  in  16  config BRAM douta.

Behaviour:
- Reset values:
  - CMD_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0.
  - CPU_BUS EN=0, WE=0, BRAM_ADDR=0, DATA_IN=0, BRAM_SELECT=`BRAM_CONFIG_SELECT.
  - State IDLE. CMD_READY rises the first cycle after reset release.
- Reset mid-operation: the bus is released asynchronously, no response is issued, and the command is lost.
- IDLE:
  - CMD_READY=1 only in IDLE.
  - On handshake, latch all CMD_* fields and set word counter i=0.
  - Go to WRITE if CMD_WRITE=1, else RD_ISSUE.
- WRITE:
  - Each cycle: EN=1, WE=1, ADDR=latched_addr+i (6-bit wrap, 0x3F+1=0x00), DATA_IN=word i. One word per cycle.
  - After word CMD_LEN: go to SET_INIT if CMD_INIT!=0, else RESPOND.
- SET_INIT: one cycle with EN=1, WE=1, ADDR=0x13, DATA_IN={14'd0, CMD_INIT}. Then POLL_WAIT with poll count n=0.
- POLL_WAIT:
  - Idle POLL_INTERVAL cycles with EN=0, then one EN=1, WE=0 read of 0x13.
  - Wait RD_LATENCY cycles, sample CPU_DATA_IN, n++.
  - If (sample[1:0] & CMD_INIT)==0, go to RESPOND with ERR=0.
  - Else if n==POLL_TIMEOUT, go to RESPOND with ERR=1.
  - Else repeat.
- RD_ISSUE / RD_WAIT:
  - One read per word: EN=1, WE=0 for one cycle, ADDR=latched_addr+i.
  - Sample CPU_DATA_IN exactly RD_LATENCY cycles later into RSP_DATA[16i+15:16i].
  - Reads are not pipelined (issue, wait, sample, next).
  - Words beyond CMD_LEN stay 0.
- RESPOND: RSP_VALID=1 for one cycle with RSP_DATA and RSP_ERR held until the next command. Then IDLE.
- Latency:
  - Write without init: response at CMD_LEN+2 cycles after handshake.
  - Read: (CMD_LEN+1)*(RD_LATENCY+1)+1 cycles after handshake.
- WE is never asserted without EN. EN is low in all idle/wait cycles.
- RSP_DATA is cleared at accept of each new read command. Write responses return RSP_DATA=0.

Decomposition:
- Shared package holds:
  - BRAM word addresses (CTRL_FLAG 0x00, FPGA_INFO 0x01, SEQ_CYCLE 0x02, SEQ_DIV 0x03, WAVELENGTH 0x08, SEQ_SYNC_TIME_0..3 0x09-0x0C, MOD_CYCLE 0x0D, MOD_DIV 0x0E, MOD_SYNC_TIME_0..3 0x0F-0x12, CLK_INIT_FLAG 0x13).
  - Ctrl/init bit indices and the state enum typedef.
- The FPGA-side config logic must import the same address package.
- No sub-module; a single FSM plus counters.

Test Plan:
- Write ADDR=0x0F, LEN=3, DATA=0x0123_4567_89AB_CDEF, INIT=0 -> four consecutive write cycles with addr/data 0x0F/CDEF, 0x10/89AB, 0x11/4567, 0x12/0123; RSP_VALID at cycle 5, ERR=0.
- Read ADDR=0x01, LEN=0, BRAM model returns 0x0001 -> one EN read of 0x01; RSP_DATA=0x...0001 at cycle (RD_LATENCY+1)+1 = 4.
- Write ADDR=0x0D, LEN=1, INIT=2'b01; model clears 0x13 after the 3rd poll -> writes to 0x0D, 0x0E, then 0x0013=0x0001; three polls of 0x13; RSP_ERR=0.
- Same as previous but the model never clears 0x13 -> exactly 64 poll reads, then RSP_VALID with RSP_ERR=1.
- Write ADDR=0x3F, LEN=1 -> second word goes to address 0x00 (wrap).
- Assert RST_N low during POLL_WAIT -> EN/WE low immediately, no RSP_VALID; after release CMD_READY=1 and a new read completes normally.
